// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad (Pmod KYPD style). One row is driven
// low at a time; the columns are synchronised, a press is debounced, decoded
// to its hex legend and reported with a one-clock key_valid strobe. The
// accepted key is then held until a debounced release is seen.
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   defined   -> while a key is held, key_valid re-strobes every REPEAT_CYCLES
//                clocks with the same key_code.
//   undefined -> exactly one key_valid per press; no repeat logic is built.
//
// Ports:
//   clk        system clock
//   res        asynchronous, active-high reset
//   col[3:0]   keypad columns, active-low, asynchronous to clk
//   row[3:0]   keypad row drive, active-low, exactly one bit low
//   key_valid  one-clock strobe per accepted key event
//   key_code   hex code of the last accepted key, held between strobes
//   key_held   high while the accepted key remains pressed
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       res,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    // Counter width covers the largest timing parameter.
    localparam int MAX_AB    = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int MAX_PARAM = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int CW        = $clog2(MAX_PARAM) + 1;

    localparam logic [CW-1:0] DWELL_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [3:0]    col_meta;
    logic [3:0]    col_s;
    logic [1:0]    row_idx;
    logic [1:0]    lat_col;
    logic [CW-1:0] dwell_cnt;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] rel_cnt;

    logic          col_idle;
    logic          key_low;
    logic          dwell_done;
    logic          deb_done;
    logic          rel_done;
    logic          row_empty;
    logic          press_found;
    logic          bounce_abort;
    logic          accept;
    logic          release_done;
    logic          row_advance;
    logic          rep_fire;

    // Lowest-index low column wins when several keys share the driven row.
    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        casez (c)
            4'b???0: return 2'd0;
            4'b??01: return 2'd1;
            4'b?011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Keypad legend: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // -------------------------------------------------------------------------
    // Column synchroniser. Resets to the idle (all-high) pattern so nothing
    // looks pressed while the first real samples ripple through.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        // NOTE: non-blocking assignments keep both flops sampling the same
        // edge; blocking here would collapse the synchroniser to one stage.
        if (res) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= col;
            col_s    <= col_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Event decode shared by the FSM and the datapath.
    // -------------------------------------------------------------------------
    assign col_idle     = (col_s == 4'hF);
    assign key_low      = ~col_s[lat_col];
    assign dwell_done   = (dwell_cnt == DWELL_LAST);
    assign deb_done     = (deb_cnt == STABLE_LAST);
    assign rel_done     = (rel_cnt == STABLE_LAST);

    assign row_empty    = (state == SCAN) && dwell_done && col_idle;
    assign press_found  = (state == SCAN) && dwell_done && !col_idle;
    assign bounce_abort = (state == DEBOUNCE) && !key_low;
    assign accept       = (state == DEBOUNCE) && key_low && deb_done;
    assign release_done = (state == HOLD) && col_idle && rel_done;

    // Leaving DEBOUNCE/HOLD resumes at the row after the latched one.
    assign row_advance  = row_empty || bounce_abort || release_done;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            SCAN: begin
                if (press_found) begin
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!key_low) begin
                    state_next = SCAN;
                end else if (deb_done) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (release_done) begin
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. Row is a one-cold decode of the index, so exactly one
    // row is ever driven low.
    // -------------------------------------------------------------------------
    always_comb begin
        row      = ~(4'b0001 << row_idx);
        key_held = (state == HOLD);
    end

    // -------------------------------------------------------------------------
    // Datapath: row index, latched column, counters, key code and strobe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            row_idx   <= 2'd0;
            lat_col   <= 2'd0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            if (row_advance) begin
                row_idx <= row_idx + 2'd1;
            end

            if (press_found) begin
                lat_col <= lowest_low(col_s);
            end

            // Dwell restarts whenever SCAN is (re)entered.
            if ((state == SCAN) && !dwell_done) begin
                dwell_cnt <= dwell_cnt + CW'(1);
            end else begin
                dwell_cnt <= '0;
            end

            // Press counter: consecutive low clocks of the latched column.
            if ((state == DEBOUNCE) && key_low && !deb_done) begin
                deb_cnt <= deb_cnt + CW'(1);
            end else begin
                deb_cnt <= '0;
            end

            // Release counter: consecutive all-high clocks; any low clears it.
            if ((state == HOLD) && col_idle && !rel_done) begin
                rel_cnt <= rel_cnt + CW'(1);
            end else begin
                rel_cnt <= '0;
            end

            if (accept) begin
                key_code <= decode_key(row_idx, lat_col);
            end

            // Registered so the strobe lines up with the new key_code.
            key_valid <= accept || rep_fire;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // -------------------------------------------------------------------------
    // Auto-repeat: runs only in HOLD while the latched key reads low; is zero
    // on HOLD entry and cleared by any release glitch.
    // -------------------------------------------------------------------------
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0] rep_cnt;
    logic          rep_done;

    assign rep_done = (rep_cnt == REPEAT_LAST);
    assign rep_fire = (state == HOLD) && key_low && rep_done;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rep_cnt <= '0;
        end else if ((state == HOLD) && key_low && !rep_done) begin
            rep_cnt <= rep_cnt + CW'(1);
        end else begin
            rep_cnt <= '0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Emulates the keypad matrix (pressed-key mask + driven row -> columns) and
// compares the scanner against a time-cursor reference model that walks each
// stimulus trace the way a person would read the scanning rules: dwell on a
// row, look at the columns, count stable clocks, hold, release. Directed
// traces reproduce the scenarios of interest; random traces widen coverage.
// Honours KEYPAD_REPEAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int REP      = 20;
    localparam int MAXN     = 400;

    logic       clk;
    logic       res;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [15:0] mask_drv;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk       (clk),
        .res       (res),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus trace and model expectations, indexed by cycle after reset.
    logic [15:0] mask_tr   [MAXN];
    logic [3:0]  exp_row   [MAXN];
    logic [3:0]  exp_code  [MAXN];
    logic        exp_valid [MAXN];
    logic        exp_held  [MAXN];
    logic [3:0]  obs_row   [MAXN];

    int          strobe_q[$];
    logic [3:0]  last_code;
    int          held_cycles;

    int n_checks;
    int n_pass;

    // Matrix emulation: a pressed key pulls its column low while its row is driven.
    function automatic logic [3:0] keypad(input logic [15:0] m, input logic [3:0] r);
        logic [3:0] c;
        c = 4'hF;
        for (int ri = 0; ri < 4; ri++) begin
            for (int ci = 0; ci < 4; ci++) begin
                if (!r[ri] && m[ri*4+ci]) c[ci] = 1'b0;
            end
        end
        return c;
    endfunction

    always_comb col = keypad(mask_drv, row);

    function automatic logic [3:0] key_name(input int idx);
        logic [63:0] map;
        map = {4'hD, 4'hE, 4'hF, 4'h0, 4'hC, 4'h9, 4'h8, 4'h7,
               4'hB, 4'h6, 4'h5, 4'h4, 4'hA, 4'h3, 4'h2, 4'h1};
        return map[idx*4 +: 4];
    endfunction

    function automatic int lowest(input logic [3:0] c);
        for (int i = 0; i < 4; i++) begin
            if (!c[i]) return i;
        end
        return 0;
    endfunction

    // Columns as seen by the scanner's decisions in cycle k (two-clock delay).
    function automatic logic [3:0] sync_col(input int k);
        if (k < 2) return 4'hF;
        return keypad(mask_tr[k-2], exp_row[k-2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic put(input int t, input int r, input logic held, input logic [3:0] code, input int n);
        if (t < n) begin
            exp_row[t]  = ~(4'b0001 << r);
            exp_held[t] = held;
            exp_code[t] = code;
        end
    endtask

    // Reference model: walks the trace with a time cursor.
    task automatic build_model(input int n);
        int         t;
        int         r;
        int         lc;
        int         cnt;
        int         rep;
        logic [3:0] code;
        logic [3:0] c;
        bit         accepted;
        for (int i = 0; i < MAXN; i++) begin
            exp_valid[i] = 1'b0;
            exp_row[i]   = 4'hE;
            exp_code[i]  = 4'h0;
            exp_held[i]  = 1'b0;
        end
        t = 0; r = 0; code = 4'h0; rep = 0;
        while (t < n) begin
            // Dwell on row r, then look at the columns on the last dwell clock.
            for (int d = 0; d < SCAN_DIV; d++) put(t + d, r, 1'b0, code, n);
            t += SCAN_DIV;
            if (t >= n) break;
            c = sync_col(t - 1);
            if (c == 4'hF) begin
                r = (r + 1) % 4;
                continue;
            end
            lc = lowest(c);
            // Debounce: need DEB consecutive low clocks on that column.
            cnt = 0; accepted = 1'b0;
            while (t < n) begin
                put(t, r, 1'b0, code, n);
                c = sync_col(t);
                t++;
                if (c[lc]) break;
                if (cnt == DEB - 1) begin
                    accepted = 1'b1;
                    break;
                end
                cnt++;
            end
            if (!accepted) begin
                r = (r + 1) % 4;
                continue;
            end
            code = key_name(r * 4 + lc);
            if (t < n) exp_valid[t] = 1'b1;
            // Hold until DEB consecutive all-high clocks.
            cnt = 0; rep = 0;
            while (t < n) begin
                put(t, r, 1'b1, code, n);
                c = sync_col(t);
                t++;
`ifdef KEYPAD_REPEAT_EN
                if (!c[lc]) begin
                    if (rep == REP - 1) begin
                        if (t < n) exp_valid[t] = 1'b1;
                        rep = 0;
                    end else begin
                        rep++;
                    end
                end else begin
                    rep = 0;
                end
`endif
                if (c == 4'hF) begin
                    if (cnt == DEB - 1) break;
                    cnt++;
                end else begin
                    cnt = 0;
                end
            end
            r = (r + 1) % 4;
        end
    endtask

    task automatic clear_tr();
        for (int i = 0; i < MAXN; i++) mask_tr[i] = 16'h0;
    endtask

    task automatic press(input int idx, input int lo, input int hi);
        for (int k = lo; k < hi && k < MAXN; k++) mask_tr[k] = mask_tr[k] | (16'(1) << idx);
    endtask

    task automatic gen_random(input int n);
        int          k;
        int          dur;
        int          bounce;
        logic [15:0] m;
        clear_tr();
        k = 0;
        while (k < n) begin
            k += $urandom_range(0, 30);
            dur = $urandom_range(4, 70);
            m = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) m = m | (16'(1) << $urandom_range(0, 15));
            bounce = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            for (int j = 0; j < dur && k < n; j++) begin
                if (bounce != 0 && j < 12 && ((j / bounce) % 2 == 1)) mask_tr[k] = 16'h0;
                else mask_tr[k] = m;
                k++;
            end
        end
    endtask

    // Reset (checking the immediate effect), then play the trace and compare
    // every cycle. Called and returns on a falling clock edge.
    task automatic run_seg(input string name, input int n);
        build_model(n);
        res = 1'b1;
        #1;
        check({name, " rst_row"},   32'(row),       32'(4'b1110));
        check({name, " rst_valid"}, 32'(key_valid), 32'(1'b0));
        check({name, " rst_code"},  32'(key_code),  32'(4'h0));
        check({name, " rst_held"},  32'(key_held),  32'(1'b0));
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
        strobe_q.delete();
        last_code   = 4'h0;
        held_cycles = 0;
        for (int k = 0; k < n; k++) begin
            mask_drv = mask_tr[k];
            #1;
            check($sformatf("%s c%0d", name, k),
                  32'({row, key_valid, key_code, key_held}),
                  32'({exp_row[k], exp_valid[k], exp_code[k], exp_held[k]}));
            obs_row[k] = row;
            if (key_valid) begin
                strobe_q.push_back(k);
                last_code = key_code;
            end
            if (key_held) held_cycles++;
            @(negedge clk);
        end
    endtask

    int early;

    initial begin
        res      = 1'b1;
        mask_drv = 16'h0;
        n_checks = 0;
        n_pass   = 0;
        @(negedge clk);

        // Idle rotation: 4-clock dwell per row, order 0,1,2,3,0.
        clear_tr();
        run_seg("rotate", 20);
        check("rot_c0",  32'(obs_row[0]),  32'(4'b1110));
        check("rot_c3",  32'(obs_row[3]),  32'(4'b1110));
        check("rot_c4",  32'(obs_row[4]),  32'(4'b1101));
        check("rot_c8",  32'(obs_row[8]),  32'(4'b1011));
        check("rot_c12", 32'(obs_row[12]), 32'(4'b0111));
        check("rot_c16", 32'(obs_row[16]), 32'(4'b1110));

        // Clean press of "6" (row1, col2) for 60 clocks.
        clear_tr();
        press(6, 0, 60);
        run_seg("key6", 100);
        check("key6_strobes", strobe_q.size(), 1);
        check("key6_code", 32'(last_code), 32'(4'h6));
        check("key6_held_cycles", held_cycles, 54);

        // Bouncing "D" (row3, col3): 3-clock toggles for 30 clocks, then stable.
        clear_tr();
        for (int k = 0; k < 30; k++) begin
            if ((k / 3) % 2 == 0) press(15, k, k + 1);
        end
        press(15, 30, 50);
        run_seg("bounceD", 90);
        early = 0;
        foreach (strobe_q[i]) if (strobe_q[i] < 32) early++;
        check("bounceD_early_strobes", early, 0);
        check("bounceD_strobes", strobe_q.size(), 1);
        check("bounceD_code", 32'(last_code), 32'(4'hD));

        // Keys "1" and "3" together in row0; "2" added during HOLD.
        clear_tr();
        press(0, 0, 50);
        press(2, 0, 50);
        press(1, 20, 50);
        run_seg("multi", 80);
        check("multi_strobes", strobe_q.size(), 1);
        check("multi_code", 32'(last_code), 32'(4'h1));

        // Hold "0" (row3, col0) for 70 clocks past acceptance.
        clear_tr();
        press(12, 0, 94);
        run_seg("hold0", 130);
        check("hold0_first_strobe", (strobe_q.size() > 0) ? strobe_q[0] : -1, 24);
`ifdef KEYPAD_REPEAT_EN
        check("hold0_strobes", strobe_q.size(), 4);
`else
        check("hold0_strobes", strobe_q.size(), 1);
`endif

        // "8" accepted, released, pressed again; trace stops mid-debounce so
        // the next reset lands there.
        clear_tr();
        press(9, 0, 30);
        press(9, 45, 60);
        run_seg("key8", 60);
        check("key8_strobes", strobe_q.size(), 1);
        check("key8_code", 32'(last_code), 32'(4'h8));
        check("key8_mid_debounce_row", 32'(row), 32'(4'b1011));

        // Reset from mid-debounce, then 40 idle clocks: no strobe.
        clear_tr();
        run_seg("post_reset", 40);
        check("post_reset_strobes", strobe_q.size(), 0);

        // Random press/bounce/multi-key traces.
        for (int s = 0; s < 6; s++) begin
            gen_random(300);
            run_seg($sformatf("rand%0d", s), 300);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
